lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store sequencer sitting between the pipeline MEM stage and `data_memory`. It accepts byte/halfword/word load and store requests over a valid/ready handshake and drives `data_memory`'s word-only interface. That interface has a combinational read and a write on the clock edge. Sub-word stores are done as read-modify-write. Loads return sign- or zero-extended data with a one-cycle response pulse.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: request rejected; qualified by `rsp_valid`.
- `mem_address` out 32: word-aligned address to `data_memory`.
- `mem_write` out 1: write strobe to `data_memory`.
- `mem_write_data` out 32: merged word to `data_memory`.
- `mem_read_data` in 32: combinational read data from `data_memory`.

## Operation
- **Handshake**
  - Acceptance happens when `req_valid && req_ready`.
  - All request fields are latched at acceptance, so inputs may change afterwards.
  - `req_ready` = 1 only in IDLE. `req_valid` while busy is ignored, not queued.
- **States:** IDLE, RD, WR, RD2, WR2, RESP. The last two active states before RESP depend on the request.
- **Transitions from IDLE on acceptance**
  - Load → RD → RESP.
  - Aligned word store → WR → RESP.
  - Sub-word store → RD → WR → RESP.
  - Error → RESP.
- **Memory drive**
  - In RD/WR: `mem_address = {addr[31:2],2'b00}`.
  - In RD2/WR2: `mem_address = {addr[31:2],2'b00} + 4`, modulo 2^32.
  - In any other state, `mem_address` = 0.
  - `mem_write` = 1 only in WR/WR2.
- **Lanes:** little-endian; byte k of a word is `[8k+7:8k]`.
- **Loads**
  - Extract the size-wide field at `addr[1:0]` from the latched word(s).
  - Extend per `req_unsigned`.
- **Stores**
  - The word captured in RD is merged with the low `size` bytes of `req_wdata` at `addr[1:0]`.
  - All other bytes are unchanged.
- **Errors**
  - `req_size` = 3 always raises `rsp_err`.
  - Misaligned access raises `rsp_err` unless the macro below is defined.
  - An error performs no memory access; `rsp_rdata` = 0.
- **Addressing:** no range checking; memory depth is `data_memory`'s concern.

## Timing
- **Reset values:** state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `mem_write` 0, `mem_address` 0, `mem_write_data` 0.
- **Latency, acceptance cycle = T:**
  - Load and aligned word store: `rsp_valid` at T+2.
  - Sub-word store: `rsp_valid` at T+3.
  - Error: `rsp_valid` at T+1.
- **Read capture:** `mem_read_data` is captured at the end of RD/RD2; the memory is combinational.
- **RESP:** lasts exactly one cycle, then IDLE. The next acceptance is possible in the cycle after `rsp_valid`.
- **Reset mid-operation**
  - Takes effect at the next edge: IDLE, no response issued.
  - A write already committed in WR stays in memory; WR2 is not performed.
- **Read-after-write:** a load accepted after a store's `rsp_valid` observes the stored data.

## Configuration
- **Macro:** `LSU_MISALIGN_EN`.
- **Defined**
  - An access spanning a word boundary uses two words.
  - Spanning cases: half at offset 3; word at offset 1–3.
  - Loads: RD → RD2 → RESP; the result is assembled from both words.
  - Stores: RD → WR → RD2 → WR2 → RESP, with both words read-modify-written.
  - A half at offset 1 does not span, so it stays single-word.
  - Latency: spanning load T+3, spanning store T+5.
- **Not defined**
  - Any half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0, → `rsp_err` at T+1, no write.
  - RD2/WR2 are compiled out.

## Structure
- **Package `lsu_pkg`:**
  - size encodings: `LSU_BYTE`, `LSU_HALF`, `LSU_WORD`;
  - state enum;
  - lane-offset constants.
- **Sub-module `lsu_lane_align`** (combinational):
  - load extract/extend from a 64-bit two-word window;
  - store merge into one word given offset/size/word-select.
- **Top module:** FSM and latches.

## Test plan
Memory holds the power-on pattern RAM[i] = i.
1. LW 0x10 → `rsp_valid` at T+2, `rsp_rdata` 0x00000004, `rsp_err` 0, `mem_write` never 1.
2. SB 0x21 data 0x000000AB, then LB 0x21 → 0xFFFFFFAB. Then LBU 0x21 → 0x000000AB, LW 0x20 → 0x0000AB08.
3. SH 0x32 data 0x1234 (RMW, `rsp_valid` at T+3), then LW 0x30 → 0x1234000C; LH 0x32 → 0x00001234.
4. LW 0x06:
   - without macro → `rsp_err` 1 at T+1, `rsp_rdata` 0;
   - with `LSU_MISALIGN_EN` → 0x00020000 at T+3.
5. Back-to-back `req_valid` held high through a load: second request accepted only in the cycle after the first `rsp_valid`; `req_ready` 0 throughout.
6. Assert `reset` during WR of SB 0x44 data 0xFF → next cycle IDLE, no `rsp_valid`. LW 0x44 then returns 0x000000FF if WR committed, otherwise 0x00000011.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory port: access sizes, sequencer
// states, lane constants and small size/span helpers.
package lsu_pkg;

    localparam logic [1:0] LSU_BYTE = 2'd0;
    localparam logic [1:0] LSU_HALF = 2'd1;
    localparam logic [1:0] LSU_WORD = 2'd2;
    localparam logic [1:0] LSU_RSVD = 2'd3;

    localparam logic [1:0]  LANE_0    = 2'd0;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RD2,
        ST_WR2,
        ST_RESP
    } lsu_state_e;

    function automatic logic [2:0] lsu_nbytes(input logic [1:0] size);
        case (size)
            LSU_BYTE: return 3'd1;
            LSU_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    // True when the access runs past the end of its first word.
    function automatic logic lsu_spans(input logic [1:0] off, input logic [1:0] size);
        return ({1'b0, off} + lsu_nbytes(size)) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_mem_port_align.sv
// Combinational lane logic: load extract/extend from a two-word window and
// store merge of right-aligned data into one word of that window.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] win_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic        word_sel_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [31:0] ld_raw;
    logic [2:0]  nbytes;
    logic [2:0]  pos;
    logic [2:0]  rel;

    assign ld_raw = win_i[{off_i, 3'b000} +: 32];
    assign nbytes = lsu_nbytes(size_i);

    always_comb begin
        ld_data_o = ld_raw;
        case (size_i)
            LSU_BYTE: ld_data_o = {{24{~unsigned_i & ld_raw[7]}}, ld_raw[7:0]};
            LSU_HALF: ld_data_o = {{16{~unsigned_i & ld_raw[15]}}, ld_raw[15:0]};
            default:  ld_data_o = ld_raw;
        endcase
    end

    // pos is the byte position inside the window; word_sel picks the upper word.
    always_comb begin
        st_word_o = word_i;
        pos       = 3'd0;
        rel       = 3'd0;
        for (int k = 0; k < 4; k++) begin
            pos = {word_sel_i, 2'(k)};
            rel = pos - {1'b0, off_i};
            if (pos >= {1'b0, off_i} && rel < nbytes)
                st_word_o[k*8 +: 8] = wdata_i[{rel[1:0], 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store sequencer in front of a word-only, combinational-read memory.
// Define LSU_MISALIGN_EN to allow word-spanning accesses (two-word sequences).
module lsu_mem_port
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  state_q;
    logic        ready_q, rsp_valid_q, rsp_err_q, mem_write_q;
    logic [31:0] rsp_rdata_q, mem_addr_q, mem_wdata_q;
    logic        write_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        err_d, span_d;
    logic [31:0] word_base;
    logic [63:0] win;
    logic        word_sel;
    logic [31:0] ld_data, st_word;

    always_comb begin
        err_d  = (req_size == LSU_RSVD);
        span_d = 1'b0;
`ifdef LSU_MISALIGN_EN
        span_d = lsu_spans(req_addr[1:0], req_size);
`else
        if (req_size == LSU_HALF && req_addr[0])
            err_d = 1'b1;
        if (req_size == LSU_WORD && req_addr[1:0] != LANE_0)
            err_d = 1'b1;
`endif
    end

    assign word_base = {addr_q[31:2], 2'b00};

`ifdef LSU_MISALIGN_EN
    logic        span_q;
    logic [31:0] lo_q;
    logic [31:0] next_base;

    assign next_base = word_base + ADDR_STEP;
    assign word_sel  = (state_q == ST_RD2);
    assign win       = word_sel ? {mem_read_data, lo_q} : {32'h0, mem_read_data};
`else
    assign word_sel  = 1'b0;
    assign win       = {32'h0, mem_read_data};
`endif

    lsu_lane_align u_align (
        .win_i      (win),
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .word_sel_i (word_sel),
        .wdata_i    (wdata_q),
        .word_i     (mem_read_data),
        .ld_data_o  (ld_data),
        .st_word_o  (st_word)
    );

    // Outputs are registered for the state being entered, so each is valid for that whole state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid) begin
                        ready_q <= 1'b0;
                        write_q <= req_write;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_EN
                        span_q  <= span_d;
`endif
                        if (err_d) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (req_write && req_size == LSU_WORD && !span_d) begin
                            state_q     <= ST_WR;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q    <= ST_RD;
                            mem_addr_q <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                ST_RD: begin
                    if (write_q) begin
                        state_q     <= ST_WR;
                        mem_addr_q  <= word_base;
                        mem_write_q <= 1'b1;
                        mem_wdata_q <= st_word;
`ifdef LSU_MISALIGN_EN
                    end else if (span_q) begin
                        state_q    <= ST_RD2;
                        lo_q       <= mem_read_data;
                        mem_addr_q <= next_base;
`endif
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ld_data;
                    end
                end
                ST_WR: begin
`ifdef LSU_MISALIGN_EN
                    if (span_q) begin
                        state_q    <= ST_RD2;
                        mem_addr_q <= next_base;
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                    end
`else
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
`endif
                end
`ifdef LSU_MISALIGN_EN
                ST_RD2: begin
                    if (write_q) begin
                        state_q     <= ST_WR2;
                        mem_addr_q  <= next_base;
                        mem_write_q <= 1'b1;
                        mem_wdata_q <= st_word;
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ld_data;
                    end
                end
                ST_WR2: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                end
`endif
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready      = ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign mem_address    = mem_addr_q;
    assign mem_write      = mem_write_q;
    assign mem_write_data = mem_wdata_q;

endmodule
